seg_scan_capture: RTL and testbench

- Inverse of the team's BCD-to-7-segment decoder. Snoops a multiplexed, scanned 7-segment bus (segment pattern plus one-cold digit select) and recovers the decimal value shown on each digit.
- Used on the UART display path for loopback self-check: a captured frame of digits can be compared with, or sent back over, the UART.
- Filters scan glitches with a stability window and publishes a complete frame atomically.

---
 rtl/seg_scan_capture.sv | 139 +++++++++++++
 tb/tb_seg_scan_capture.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_capture.sv
// Snoops a scanned, multiplexed 7-segment bus and recovers the digit values.
// Ports: iClk/iRst, iSeg/iDigSel in; oDigits/oDp/oValid/oErr/oSelErr/oErrDigit out.
module seg_scan_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic [7:0]              iSeg,
  input  logic [NUM_DIGITS-1:0]   iDigSel,
  output logic [4*NUM_DIGITS-1:0] oDigits,
  output logic [NUM_DIGITS-1:0]   oDp,
  output logic                    oValid,
  output logic                    oErr,
  output logic                    oSelErr,
  output logic [2:0]              oErrDigit
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] C_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] C_PRE = CW'(STABLE_CYCLES - 1);

  logic [7:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_sel;
  logic [CW-1:0]           r_cnt;
  logic                    r_acc;
  logic [4*NUM_DIGITS-1:0] r_wdig;
  logic [NUM_DIGITS-1:0]   r_wdp;
  logic [NUM_DIGITS-1:0]   r_seen;

  logic                    w_match;
  logic [NUM_DIGITS-1:0]   w_zeros;
  logic [NUM_DIGITS-1:0]   w_hit;
  logic                    w_blank;
  logic                    w_onecold;
  logic [2:0]              w_idx;
  logic [3:0]              w_val;
  logic                    w_bad;

  assign w_match = (iSeg == r_seg) && (iDigSel == r_sel);

  // Select classification works on the registered pair so the
  // accepted value is the one that was actually stable.
  assign w_zeros   = ~r_sel;
  assign w_hit     = w_zeros & (~w_zeros + 1'b1);
  assign w_blank   = (w_zeros == '0);
  assign w_onecold = !w_blank && (w_zeros == w_hit);

  always_comb begin
    w_idx = 3'd0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (w_zeros[i]) w_idx = 3'(i);
    end
  end

  always_comb begin
    w_val = 4'hE;
    w_bad = 1'b0;
    unique case (r_seg[7:1])
      7'b0000001: w_val = 4'd0;
      7'b1001111: w_val = 4'd1;
      7'b0010010: w_val = 4'd2;
      7'b0000110: w_val = 4'd3;
      7'b1001100: w_val = 4'd4;
      7'b0100100: w_val = 4'd5;
      7'b0100000: w_val = 4'd6;
      7'b0001111: w_val = 4'd7;
      7'b0000000: w_val = 4'd8;
      7'b0000100: w_val = 4'd9;
      7'b1001000: w_val = 4'hF;
      default: begin
        w_val = 4'hE;
        w_bad = 1'b1;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_seg     <= 8'hFF;
      r_sel     <= '1;
      r_cnt     <= '0;
      r_acc     <= 1'b0;
      r_wdig    <= '0;
      r_wdp     <= '0;
      r_seen    <= '0;
      oDigits   <= '0;
      oDp       <= '0;
      oValid    <= 1'b0;
      oErr      <= 1'b0;
      oSelErr   <= 1'b0;
      oErrDigit <= 3'd0;
    end else begin
      oValid  <= 1'b0;
      oErr    <= 1'b0;
      oSelErr <= 1'b0;

      if (w_match) begin
        if (r_cnt != C_MAX) r_cnt <= r_cnt + 1'b1;
      end else begin
        r_seg <= iSeg;
        r_sel <= iDigSel;
        r_cnt <= CW'(1);
      end

      // Only the step into saturation arms the strobe, so a held
      // pair is accepted once.
      r_acc <= w_match && (r_cnt == C_PRE);

      // Completion is the edge after the last write; writes are at
      // least two edges apart, so this never races a write.
      if (&r_seen) begin
        oDigits <= r_wdig;
        oDp     <= r_wdp;
        oValid  <= 1'b1;
        r_seen  <= '0;
      end

      if (r_acc && !w_blank) begin
        if (!w_onecold) begin
          oSelErr <= 1'b1;
        end else begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_hit[i]) begin
              r_wdig[4*i +: 4] <= w_val;
              r_wdp[i]         <= ~r_seg[0];
              r_seen[i]        <= 1'b1;
            end
          end
          if (w_bad) begin
            oErr      <= 1'b1;
            oErrDigit <= w_idx;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: frames, glitches, errors, reset.
// Drives on the falling edge, checks on the falling edge.
module tb_seg_scan_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg;
  logic [3:0]  sel;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        valid;
  logic        err;
  logic        selerr;
  logic [2:0]  errdig;

  int errors = 0;
  int checks = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_selerr = 0;

  seg_scan_capture #(
    .NUM_DIGITS(4),
    .STABLE_CYCLES(4)
  ) dut (
    .iClk(clk),
    .iRst(rst),
    .iSeg(seg),
    .iDigSel(sel),
    .oDigits(digits),
    .oDp(dp),
    .oValid(valid),
    .oErr(err),
    .oSelErr(selerr),
    .oErrDigit(errdig)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (valid) n_valid++;
    if (err) n_err++;
    if (selerr) n_selerr++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a pair at the current falling edge and hold it n edges.
  task automatic step(input logic [7:0] s,
                      input logic [3:0] d,
                      input int n);
    seg = s;
    sel = d;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    seg = 8'h00;
    sel = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_dp", 32'(dp), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_selerr", 32'(selerr), 32'h0);
    chk("rst_errdig", 32'(errdig), 32'h0);
    seg = 8'hFF;
    sel = 4'hF;
    rst = 1'b0;

    step(8'h03, 4'hE, 6);
    step(8'h9F, 4'hD, 6);
    step(8'h25, 4'hB, 6);
    step(8'h0D, 4'h7, 6);
    chk("f1_valid", 32'(valid), 32'h1);
    chk("f1_digits", 32'(digits), 32'h3210);
    chk("f1_dp", 32'(dp), 32'h0);
    chk("f1_nvalid", n_valid, 1);
    chk("f1_nerr", n_err, 0);
    chk("f1_nselerr", n_selerr, 0);
    @(negedge clk);
    chk("f1_pulse", 32'(valid), 32'h0);

    step(8'h9F, 4'hD, 6);
    step(8'h25, 4'hB, 6);
    step(8'h0D, 4'h7, 6);
    step(8'h49, 4'hE, 3);
    step(8'h99, 4'hE, 4);
    chk("f2_early", n_valid, 1);
    step(8'h99, 4'hE, 1);
    chk("f2_e5_valid", 32'(valid), 32'h0);
    step(8'h99, 4'hE, 1);
    chk("f2_e6_valid", 32'(valid), 32'h1);
    chk("f2_digits", 32'(digits), 32'h3214);
    chk("f2_nvalid", n_valid, 2);

    step(8'h91, 4'hE, 5);
    chk("glyph_noerr", 32'(err), 32'h0);
    step(8'h9E, 4'hD, 5);
    step(8'hFF, 4'hB, 5);
    chk("bad_err", 32'(err), 32'h1);
    chk("bad_errdig", 32'(errdig), 32'h2);
    step(8'h0D, 4'h7, 6);
    chk("f3_valid", 32'(valid), 32'h1);
    chk("f3_digits", 32'(digits), 32'h3E1F);
    chk("f3_dp", 32'(dp), 32'h2);
    chk("f3_nerr", n_err, 1);

    step(8'h03, 4'hC, 5);
    chk("sel_err", 32'(selerr), 32'h1);
    step(8'h03, 4'hF, 5);
    chk("blank_nsel", n_selerr, 1);
    step(8'h25, 4'hB, 6);
    step(8'h0D, 4'h7, 6);
    chk("sel_noseen", n_valid, 3);
    step(8'h25, 4'hD, 6);
    step(8'h0D, 4'hD, 6);
    chk("rescan_open", n_valid, 3);
    step(8'hFF, 4'hE, 50);
    chk("hold_nerr", n_err, 2);
    chk("hold_errdig", 32'(errdig), 32'h0);
    chk("f4_nvalid", n_valid, 4);
    chk("f4_digits", 32'(digits), 32'h323E);

    step(8'h03, 4'hE, 6);
    step(8'h9F, 4'hD, 6);
    step(8'h25, 4'hB, 6);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_digits", 32'(digits), 32'h0);
    chk("mid_dp", 32'(dp), 32'h0);
    chk("mid_valid", 32'(valid), 32'h0);
    rst = 1'b0;
    step(8'h0D, 4'h7, 6);
    chk("post_rst1", n_valid, 4);
    step(8'h03, 4'hE, 6);
    step(8'h9F, 4'hD, 6);
    chk("post_rst2", n_valid, 4);
    step(8'h25, 4'hB, 6);
    chk("f5_valid", 32'(valid), 32'h1);
    chk("f5_digits", 32'(digits), 32'h3210);
    chk("f5_dp", 32'(dp), 32'h0);
    chk("f5_nvalid", n_valid, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
